// File: rtl/key_event_ctrl.sv
// Push-button controller: two-flop synchroniser, per-key debounce, press
// detection into a write-1-to-clear edge-capture register, maskable level
// interrupt, and a small Avalon-MM register window with 1-cycle read latency.
module key_event_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] irqmask_next;
  logic [31:0]      rd_mux;

  // Only the low WIDTH bits of a write carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  // Debounce: a level is accepted once sync has differed from stable for
  // DEBOUNCE_CYCLES consecutive cycles; returning to stable restarts the count.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync_q2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = sync_q2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press is the 1->0 change of stable; it lands in edgecap on the same edge
  // that updates stable, and wins over a simultaneous clear.
  always_comb begin
    press        = stable & ~stable_next;
    clr          = (write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    edgecap_next = (edgecap & ~clr) | press;
    irqmask_next = (write && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask;
  end

  // Read mux always sees pre-write state, so a colliding read returns old data.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = ~stable;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  // State registers; reset forces keys to the released level so no press fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1  <= '1;
      sync_q2  <= '1;
      stable   <= '1;
      cnt      <= '{default: '0};
      edgecap  <= '0;
      irqmask  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      sync_q1  <= in_port;
      sync_q2  <= sync_q1;
      stable   <= stable_next;
      cnt      <= cnt_next;
      edgecap  <= edgecap_next;
      irqmask  <= irqmask_next;
      irq      <= |(edgecap_next & irqmask_next);
      if (read) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl with a short debounce window. A cycle model
// predicts readdata and irq from the key rules; directed reads pin it.
module tb_key_event_ctrl;

  localparam int WIDTH = 2;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address = '0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = '1;
  logic             irq;

  int total = 0;
  int bad   = 0;

  key_event_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a key level is accepted once the synchronised pin has held that
  // same value for DB consecutive cycles.
  bit [WIDTH-1:0] m_d1, m_d2, m_stable, m_edge, m_mask, new_stable, presses;
  bit [WIDTH-1:0] m_prev;
  int             m_run [WIDTH];
  logic [31:0]    m_rd;
  logic           m_irq;
  bit             m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_d1 = '1; m_d2 = '1; m_stable = '1; m_edge = '0; m_mask = '0;
      m_prev = '1; m_rd = '0; m_irq = 1'b0; m_live = 1'b1;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      if (read) begin
        m_rd = '0;
        case (address)
          2'd0: m_rd[WIDTH-1:0] = ~m_stable;
          2'd2: m_rd[WIDTH-1:0] = m_mask;
          2'd3: m_rd[WIDTH-1:0] = m_edge;
          default: m_rd = '0;
        endcase
      end
      new_stable = m_stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_d2[i] == m_prev[i]) m_run[i]++;
        else m_run[i] = 1;
        m_prev[i] = m_d2[i];
        if (m_run[i] >= DB) new_stable[i] = m_d2[i];
      end
      presses = m_stable & ~new_stable;
      if (write && address == 2'd2) m_mask = writedata[WIDTH-1:0];
      if (write && address == 2'd3) m_edge = m_edge & ~writedata[WIDTH-1:0];
      m_edge   = m_edge | presses;
      m_stable = new_stable;
      m_irq    = |(m_edge & m_mask);
      m_d2     = m_d1;
      m_d1     = in_port;
    end
  end

  // Compare DUT outputs against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_readdata", readdata, m_rd);
      chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = '0;
  endtask

  logic [31:0] d;

  initial begin
    // 1: reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    rd(2'd0, d); chk("rst_data", d, 32'h0);
    rd(2'd2, d); chk("rst_mask", d, 32'h0);
    rd(2'd3, d); chk("rst_edge", d, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // 2: press key0, stable updates on the 6th edge after the change
    in_port = 2'b10;
    tick(5);
    rd(2'd0, d); chk("t2_data_early", d, 32'h0);
    rd(2'd0, d); chk("t2_data_on", d, 32'h1);
    rd(2'd3, d); chk("t2_edge", d, 32'h1);
    chk("t2_irq_masked", {31'b0, irq}, 32'h0);
    in_port = 2'b11;
    tick(10);
    rd(2'd0, d); chk("t2_data_rel", d, 32'h0);
    rd(2'd3, d); chk("t2_edge_sticky", d, 32'h1);
    wr(2'd3, 32'hFFFF_FFFD);
    rd(2'd3, d); chk("t2_edge_clr", d, 32'h0);

    // 3: bounce shorter than the window never settles
    for (int k = 0; k < 5; k++) begin
      in_port[0] = 1'b0; tick(2);
      in_port[0] = 1'b1; tick(2);
    end
    tick(8);
    rd(2'd3, d); chk("t3_edge", d, 32'h0);
    rd(2'd0, d); chk("t3_data", d, 32'h0);

    // 4: masked-in press of key1 raises irq; W1C drops it
    wr(2'd2, 32'hFFFF_FFF3);
    rd(2'd2, d); chk("t4_mask", d, 32'h3);
    in_port = 2'b01;
    tick(8);
    rd(2'd3, d); chk("t4_edge", d, 32'h2);
    chk("t4_irq_hi", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h2);
    chk("t4_irq_lo", {31'b0, irq}, 32'h0);
    rd(2'd3, d); chk("t4_edge_clr", d, 32'h0);
    in_port = 2'b11;
    tick(8);
    chk("t4_irq_rel", {31'b0, irq}, 32'h0);

    // 5: clear collides with the press cycle of key0; set wins
    in_port = 2'b10;
    tick(5);
    wr(2'd3, 32'h1);
    chk("t5_irq", {31'b0, irq}, 32'h1);
    rd(2'd3, d); chk("t5_edge", d, 32'h1);
    in_port = 2'b11;
    tick(8);
    wr(2'd3, 32'h3);
    chk("t5_irq_clr", {31'b0, irq}, 32'h0);

    // 6: reset mid-debounce, key held through and after reset
    in_port = 2'b10;
    tick(4);
    reset = 1'b1;
    tick(2);
    chk("t6_irq_rst", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(7);
    rd(2'd0, d); chk("t6_data", d, 32'h1);
    rd(2'd3, d); chk("t6_edge", d, 32'h1);
    rd(2'd2, d); chk("t6_mask", d, 32'h0);
    chk("t6_irq", {31'b0, irq}, 32'h0);
    rd(2'd1, d); chk("t6_rsvd", d, 32'h0);

    in_port = 2'b11;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
